sync_fifo_wconv: RTL and testbench
==================================

SYNC_FIFO_WCONV -- requirements
Module: sync_fifo_wconv

Interface
REQ-001 SHALL take parameter WR_W, default 32, write word width in bits.
REQ-002 SHALL take parameter RD_W, default 4, read slice width; WR_W SHALL be an integer multiple of RD_W; RATIO = WR_W/RD_W.
REQ-003 SHALL take parameter DEPTH, default 256, capacity in write words, power of two, >= 2.
REQ-004 SHALL take parameter AFULL_TH, default DEPTH-4, almost-full threshold in write words.
REQ-005 SHALL take parameter AEMPTY_TH, default 4, almost-empty threshold in read slices.
REQ-006 SHALL take parameter MSB_FIRST, default 0; 0 emits bits [RD_W-1:0] first, 1 emits the top slice first.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rstn  input  1  reset, synchronous, active-low.
REQ-009 i_wvld  input  1  write strobe.
REQ-010 i_wdat  input  WR_W  write data.
REQ-011 o_full  output  1  no free write word.
REQ-012 o_afull  output  1  stored write words >= AFULL_TH.
REQ-013 i_rreq  input  1  read request; consumes the current slice.
REQ-014 o_rdat  output  RD_W  current slice (FWFT).
REQ-015 o_empty  output  1  no slice available.
REQ-016 o_aempty  output  1  available slices <= AEMPTY_TH.
REQ-017 o_cnt  output  clog2(DEPTH*RATIO+1)  available slices.
REQ-018 o_ovf  output  1  one-cycle pulse: write attempted while full.
REQ-019 o_udf  output  1  one-cycle pulse: read attempted while empty.

Function
REQ-020 A write SHALL be accepted iff i_wvld=1 and o_full=0 at the clock edge; otherwise the data SHALL be dropped and o_ovf SHALL pulse high the next cycle.
REQ-021 A read SHALL be accepted iff i_rreq=1 and o_empty=0; otherwise nothing SHALL change and o_udf SHALL pulse high the next cycle.
REQ-022 o_rdat SHALL be combinationally the slice at (read word pointer, slice index) while o_empty=0, and all-zeros while o_empty=1.
REQ-023 Slice index SHALL advance on every accepted read; on reaching RATIO-1 it SHALL wrap to 0, and the read word pointer SHALL increment, freeing that word.
REQ-024 Word pointers SHALL be clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-025 Write-to-read latency: a word written at edge N SHALL make o_empty=0 and its first slice visible on o_rdat after edge N.
REQ-026 o_cnt SHALL equal (stored words)*RATIO - slice index, registered, updated on the same edge as the pointers.
REQ-027 Simultaneous accepted write and read SHALL be allowed in every state; the word count SHALL change only if the read completes a word.
REQ-028 When full, a write and a read completing a word in the same cycle: the write SHALL be dropped (full evaluated before the edge), the read SHALL proceed.
REQ-029 When empty, a write and read in the same cycle: the write SHALL be accepted, the read SHALL be rejected with o_udf.
REQ-030 o_full, o_afull, o_empty, o_aempty SHALL be registered and consistent with o_cnt on the same cycle.

Reset
REQ-031 With rstn=0 at an edge, pointers, slice index and o_cnt SHALL clear to 0; o_full=0, o_afull=0, o_empty=1, o_aempty=1, o_ovf=0, o_udf=0, o_rdat=0.
REQ-032 Reset mid-operation SHALL discard all stored data; i_wvld and i_rreq during reset SHALL be ignored.
REQ-033 Memory contents SHALL NOT require reset.

Structure
REQ-034 Shared package sync_fifo_pkg SHALL hold the pointer/count width helper function and the MSB_FIRST mode constants.
REQ-035 Storage SHALL be a sub-module sync_fifo_ram (DEPTH x WR_W, one synchronous write port, one asynchronous read port); no vendor IP.

Verification
REQ-036 Default params, write 0x76543210, then 8 reads -> o_rdat 0,1,...,7; o_empty=1 after the 8th; o_cnt 8->0.
REQ-037 MSB_FIRST=1, write 0x76543210 -> o_rdat 7,6,...,0.
REQ-038 Write 256 words no reads -> o_full=1 after 256th, o_afull=1 from 252nd, o_cnt=2048; 257th write -> o_ovf one cycle, data unchanged.
REQ-039 Full, read 8 slices while i_wvld=1 throughout -> write dropped on the freeing cycle, accepted the next; o_cnt returns to 2048.
REQ-040 Empty, i_rreq=1 with i_wvld=1 -> o_udf pulse, word stored, o_cnt=8.
REQ-041 Half-full then rstn=0 one cycle -> all outputs at reset values; subsequent write/read reproduces REQ-036.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the width-converting synchronous FIFO.
// Holds pointer/count width helpers, slice-order modes and the flag bundle.
package sync_fifo_pkg;

    localparam bit SLICE_LSB_FIRST = 1'b0;
    localparam bit SLICE_MSB_FIRST = 1'b1;

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_flags_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int depth, input int ratio);
        return $clog2(depth * ratio + 1);
    endfunction

    function automatic int idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Word storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; occupancy is tracked entirely by the pointers.
module sync_fifo_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_wconv.sv
// Synchronous FIFO accepting WR_W-bit words and emitting RD_W-bit slices
// first-word-fall-through; all status flags are registered from next state.
module sync_fifo_wconv
    import sync_fifo_pkg::*;
#(
    parameter int WR_W      = 32,
    parameter int RD_W      = 4,
    parameter int DEPTH     = 256,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    i_wvld,
    input  logic [WR_W-1:0]                         i_wdat,
    output logic                                    o_full,
    output logic                                    o_afull,
    input  logic                                    i_rreq,
    output logic [RD_W-1:0]                         o_rdat,
    output logic                                    o_empty,
    output logic                                    o_aempty,
    output logic [cnt_w(DEPTH, WR_W/RD_W)-1:0]      o_cnt,
    output logic                                    o_ovf,
    output logic                                    o_udf
);

    localparam int RATIO = WR_W / RD_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = ptr_w(DEPTH);
    localparam int CW    = cnt_w(DEPTH, RATIO);
    localparam int SW    = idx_w(RATIO);

    localparam logic [SW-1:0] LAST_IDX = SW'(RATIO - 1);
    localparam logic [CW-1:0] RATIO_C  = CW'(RATIO);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [PW-1:0]   wptr, wptr_n;
    logic [PW-1:0]   rptr, rptr_n;
    logic [PW-1:0]   words_n;
    logic [SW-1:0]   sidx, sidx_n, eidx;
    logic [CW-1:0]   cnt, cnt_n;
    fifo_flags_t     flg, flg_n;
    logic            ovf, udf;
    logic            wr_ok, rd_ok, word_done;
    logic [WR_W-1:0] rword;

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (WR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok & rstn),
        .waddr (wptr[AW-1:0]),
        .wdata (i_wdat),
        .raddr (rptr[AW-1:0]),
        .rdata (rword)
    );

    always_comb begin
        wr_ok     = i_wvld & ~flg.full;
        rd_ok     = i_rreq & ~flg.empty;
        word_done = rd_ok && (sidx == LAST_IDX);

        wptr_n = wptr + PW'(wr_ok);
        rptr_n = rptr + PW'(word_done);

        sidx_n = sidx;
        if (rd_ok) begin
            sidx_n = word_done ? '0 : sidx + SW'(1);
        end

        // Stored words include the one currently being sliced out.
        words_n = wptr_n - rptr_n;
        cnt_n   = CW'(words_n) * RATIO_C - CW'(sidx_n);

        flg_n.full   = (wptr_n[PW-1] != rptr_n[PW-1]) &&
                       (wptr_n[PW-2:0] == rptr_n[PW-2:0]);
        flg_n.empty  = (wptr_n == rptr_n);
        flg_n.afull  = (words_n >= AFULL_C);
        flg_n.aempty = (cnt_n <= AEMPTY_C);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            sidx <= '0;
            cnt  <= '0;
            flg  <= '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            wptr <= wptr_n;
            rptr <= rptr_n;
            sidx <= sidx_n;
            cnt  <= cnt_n;
            flg  <= flg_n;
            ovf  <= i_wvld & flg.full;
            udf  <= i_rreq & flg.empty;
        end
    end

    always_comb begin
        eidx = (MSB_FIRST == SLICE_MSB_FIRST) ? LAST_IDX - sidx : sidx;
        o_rdat = '0;
        if (!flg.empty) begin
            o_rdat = rword[int'(eidx) * RD_W +: RD_W];
        end
    end

    assign o_full   = flg.full;
    assign o_afull  = flg.afull;
    assign o_empty  = flg.empty;
    assign o_aempty = flg.aempty;
    assign o_cnt    = cnt;
    assign o_ovf    = ovf;
    assign o_udf    = udf;

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// Directed bench for sync_fifo_wconv with a slice-level scoreboard model.
// A second instance covers top-slice-first ordering.
module tb_sync_fifo_wconv;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wvld, rreq;
    logic [31:0] wdat;
    logic        full, afull, empty, aempty, ovf, udf;
    logic [3:0]  rdat;
    logic [11:0] cnt;

    logic        wvld2, rreq2;
    logic [31:0] wdat2;
    logic        full2, afull2, empty2, aempty2, ovf2, udf2;
    logic [3:0]  rdat2;
    logic [11:0] cnt2;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb[$];
    logic [3:0] sb2[$];

    always #5 clk = ~clk;

    sync_fifo_wconv dut (
        .clk(clk), .rstn(rstn), .i_wvld(wvld), .i_wdat(wdat),
        .o_full(full), .o_afull(afull), .i_rreq(rreq), .o_rdat(rdat),
        .o_empty(empty), .o_aempty(aempty), .o_cnt(cnt),
        .o_ovf(ovf), .o_udf(udf)
    );

    sync_fifo_wconv #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rstn(rstn), .i_wvld(wvld2), .i_wdat(wdat2),
        .o_full(full2), .o_afull(afull2), .i_rreq(rreq2), .o_rdat(rdat2),
        .o_empty(empty2), .o_aempty(aempty2), .o_cnt(cnt2),
        .o_ovf(ovf2), .o_udf(udf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int words_m();
        return (sb.size() + 7) / 8;
    endfunction

    task automatic push_word(input logic [31:0] d);
        for (int i = 0; i < 8; i++) sb.push_back(d[4*i +: 4]);
    endtask

    task automatic chk_state(input logic ovf_e, input logic udf_e);
        chk("cnt",    32'(cnt),    32'(sb.size()));
        chk("full",   32'(full),   32'(words_m() == 256));
        chk("afull",  32'(afull),  32'(words_m() >= 252));
        chk("empty",  32'(empty),  32'(sb.size() == 0));
        chk("aempty", 32'(aempty), 32'(sb.size() <= 4));
        chk("ovf",    32'(ovf),    32'(ovf_e));
        chk("udf",    32'(udf),    32'(udf_e));
    endtask

    task automatic cyc(input logic w, input logic [31:0] d, input logic r);
        logic full_m, empty_m, wr_ok, rd_ok;
        wvld = w;
        wdat = d;
        rreq = r;
        #1;
        full_m  = (words_m() == 256);
        empty_m = (sb.size() == 0);
        chk("rdat", 32'(rdat), empty_m ? 32'd0 : 32'(sb[0]));
        wr_ok = w && !full_m;
        rd_ok = r && !empty_m;
        @(posedge clk);
        if (rd_ok) void'(sb.pop_front());
        if (wr_ok) push_word(d);
        #1;
        chk_state(w && full_m, r && empty_m);
    endtask

    task automatic rst_cyc();
        rstn = 1'b0;
        wvld = 1'b1;
        rreq = 1'b1;
        wdat = $urandom;
        @(posedge clk);
        sb.delete();
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        wvld = 1'b0;
        rreq = 1'b0;
        chk_state(1'b0, 1'b0);
        chk("rst_rdat", 32'(rdat), 32'd0);
    endtask

    task automatic basic_word();
        cyc(1'b1, 32'h7654_3210, 1'b0);
        chk("first_cnt", 32'(cnt), 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b1);
        chk("drained_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        rstn  = 1'b0;
        wvld  = 1'b0;
        rreq  = 1'b0;
        wdat  = '0;
        wvld2 = 1'b0;
        rreq2 = 1'b0;
        wdat2 = '0;

        rst_cyc();
        basic_word();

        // Write and read together while empty: read refused, word kept.
        cyc(1'b1, 32'hA5C3_1E69, 1'b1);
        chk("udf_cnt", 32'(cnt), 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);

        for (int k = 0; k < 256; k++) cyc(1'b1, $urandom, 1'b0);
        chk("fill_cnt", 32'(cnt), 32'd2048);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
        cyc(1'b0, 32'd0, 1'b0);

        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h1357_9BDF, 1'b1);
        cyc(1'b1, 32'h1357_9BDF, 1'b0);
        chk("refill_cnt", 32'(cnt), 32'd2048);
        cyc(1'b0, 32'd0, 1'b0);

        for (int i = 0; i < 1024; i++) cyc(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

        rst_cyc();
        basic_word();

        wvld2 = 1'b1;
        wdat2 = 32'h7654_3210;
        for (int i = 7; i >= 0; i--) sb2.push_back(wdat2[4*i +: 4]);
        @(posedge clk);
        #1;
        wvld2 = 1'b0;
        chk("msb_cnt", 32'(cnt2), 32'd8);
        for (int i = 0; i < 8; i++) begin
            rreq2 = 1'b1;
            #1;
            chk("msb_rdat", 32'(rdat2), 32'(sb2.pop_front()));
            @(posedge clk);
            #1;
        end
        rreq2 = 1'b0;
        chk("msb_empty", 32'(empty2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
